// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  localparam int MIN_DATA_WIDTH = 5;
  // Distance of the outer vote samples from the bit centre, in ticks.
  localparam int VOTE_OFFSET    = 1;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_BRK_WAIT = 3'd5
  } rx_state_t;

  // The encoding 11 is an alias for "no parity".
  function automatic parity_t decode_parity(input logic [1:0] p);
    case (p)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

  // Out-of-range widths saturate rather than wrap.
  function automatic logic [3:0] clamp_bits(input logic [3:0] b, input int maxw);
    if (int'(b) < MIN_DATA_WIDTH) return 4'(MIN_DATA_WIDTH);
    if (int'(b) > maxw)           return 4'(maxw);
    return b;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchronizer, oversample tick counter and 3-sample majority vote.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_tick,
  input  logic i_RX,
  input  logic run,        // a frame is in progress; low holds tcnt at 0
  output logic rx_s,
  output logic vote,
  output logic vote_valid, // last vote sample of the bit, vote is final
  output logic bit_end     // last tick of the bit period
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] SMP_LO = TW'(OVERSAMPLE/2 - VOTE_OFFSET);
  localparam logic [TW-1:0] SMP_MD = TW'(OVERSAMPLE/2);
  localparam logic [TW-1:0] SMP_HI = TW'(OVERSAMPLE/2 + VOTE_OFFSET);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [TW-1:0]          tcnt;
  logic [1:0]             samp;

  // Metastability chain; resets to the idle (mark) level.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], i_RX};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Tick position within the current bit; restarts on every new frame.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)     tcnt <= '0;
    else if (!run)   tcnt <= '0;
    else if (i_tick) tcnt <= (tcnt == T_LAST) ? '0 : tcnt + 1'b1;
  end

  // First two vote samples; the third is taken live at SMP_HI.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) samp <= 2'b11;
    else if (run && i_tick) begin
      if (tcnt == SMP_LO) samp[0] <= rx_s;
      if (tcnt == SMP_MD) samp[1] <= rx_s;
    end
  end

  assign vote_valid = run && i_tick && (tcnt == SMP_HI);
  assign bit_end    = run && i_tick && (tcnt == T_LAST);
  assign vote       = maj3(samp[0], samp[1], rx_s);

endmodule

// File: rtl/uart_rx_core.sv
// Run-time configurable UART receiver: framing FSM, data/parity/stop
// checking and a single-entry valid/ready output holding register.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int MAX_DATA_WIDTH = 9,
  parameter int OVERSAMPLE     = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic                      i_tick,
  input  logic                      i_RX,
  input  logic [3:0]                i_cfg_data_bits,
  input  logic [1:0]                i_cfg_parity,
  input  logic                      i_cfg_stop2,
  output logic [MAX_DATA_WIDTH-1:0] o_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_parity_err,
  output logic                      o_frame_err,
  output logic                      o_break,
  output logic                      o_overrun,
  input  logic                      i_error_rst,
  output logic                      o_busy
);

  rx_state_t state;

  logic rx_s, vote, vote_valid, bit_end, run;

  // Frame configuration captured at the start edge.
  logic [3:0] eff_bits;
  parity_t    par_q;
  logic       stop2_q;

  logic [MAX_DATA_WIDTH-1:0] shreg;
  logic [3:0]                bcnt;
  logic                      par_acc;  // XOR of data votes so far
  logic                      perr, ferr;
  logic                      brk;      // every vote so far has been 0
  logic                      stop_idx; // 0 = first stop bit, 1 = second

  logic last_stop, frame_done, fin_ferr, fin_brk, par_exp, ovr_set;

  assign run = (state == ST_START) || (state == ST_DATA) ||
               (state == ST_PARITY) || (state == ST_STOP);

  uart_rx_sampler #(
    .OVERSAMPLE  (OVERSAMPLE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_tick     (i_tick),
    .i_RX       (i_RX),
    .run        (run),
    .rx_s       (rx_s),
    .vote       (vote),
    .vote_valid (vote_valid),
    .bit_end    (bit_end)
  );

  // Completion fires at the last stop bit's final vote, not at bit end,
  // so the receiver is back in IDLE before the next start edge can arrive.
  assign last_stop  = (stop_idx == stop2_q);
  assign frame_done = (state == ST_STOP) && vote_valid && last_stop;
  assign fin_ferr   = ferr | ~vote;
  // Break only looks at the first stop bit's vote.
  assign fin_brk    = brk & (stop_idx | ~vote);
  assign par_exp    = par_acc ^ (par_q == PAR_ODD);
  assign ovr_set    = frame_done && o_valid && !i_ready;

  // Framing FSM and receive datapath.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= ST_IDLE;
      eff_bits <= 4'(MIN_DATA_WIDTH);
      par_q    <= PAR_NONE;
      stop2_q  <= 1'b0;
      shreg    <= '0;
      bcnt     <= '0;
      par_acc  <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      brk      <= 1'b0;
      stop_idx <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_tick && !rx_s) begin
            state    <= ST_START;
            eff_bits <= clamp_bits(i_cfg_data_bits, MAX_DATA_WIDTH);
            par_q    <= decode_parity(i_cfg_parity);
            stop2_q  <= i_cfg_stop2;
            shreg    <= '0;
            bcnt     <= '0;
            par_acc  <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            brk      <= 1'b1;
            stop_idx <= 1'b0;
          end
        end
        ST_START: begin
          // A start bit that votes high was a glitch.
          if (vote_valid && vote) state <= ST_IDLE;
          else if (bit_end)       state <= ST_DATA;
        end
        ST_DATA: begin
          if (vote_valid) begin
            for (int i = 0; i < MAX_DATA_WIDTH; i++)
              if (4'(i) == bcnt) shreg[i] <= vote;
            par_acc <= par_acc ^ vote;
            if (vote) brk <= 1'b0;
          end
          if (bit_end) begin
            if (bcnt == eff_bits - 4'd1) begin
              bcnt  <= '0;
              state <= (par_q == PAR_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              bcnt <= bcnt + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (vote_valid) begin
            if (vote != par_exp) perr <= 1'b1;
            if (vote) brk <= 1'b0;
          end
          if (bit_end) state <= ST_STOP;
        end
        ST_STOP: begin
          if (vote_valid) begin
            if (!vote) ferr <= 1'b1;
            if (vote && !stop_idx) brk <= 1'b0;
            if (last_stop) state <= rx_s ? ST_IDLE : ST_BRK_WAIT;
          end
          // Only reached for the first of two stop bits.
          if (bit_end) stop_idx <= 1'b1;
        end
        ST_BRK_WAIT: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output holding register: a full, unaccepted register drops new frames.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
    end else if (frame_done && !(o_valid && !i_ready)) begin
      o_data       <= shreg;
      o_valid      <= 1'b1;
      o_parity_err <= perr;
      o_frame_err  <= fin_ferr;
      o_break      <= fin_brk;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

  // Sticky overrun; a new drop outranks a clear in the same cycle.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)          o_overrun <= 1'b0;
    else if (ovr_set)     o_overrun <= 1'b1;
    else if (i_error_rst) o_overrun <= 1'b0;
  end

  // Busy flag registered from the state.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) o_busy <= 1'b0;
    else         o_busy <= (state != ST_IDLE);
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomized self-checking bench for uart_rx_core with a frame-level model.
module tb_uart_rx_core;

  localparam int MW = 9;
  localparam int OS = 16;
  localparam int SS = 2;

  logic          i_clk = 1'b0;
  logic          i_rstn = 1'b0;
  logic          i_tick = 1'b0;
  logic          i_RX = 1'b1;
  logic [3:0]    i_cfg_data_bits = 4'd8;
  logic [1:0]    i_cfg_parity = 2'b00;
  logic          i_cfg_stop2 = 1'b0;
  logic [MW-1:0] o_data;
  logic          o_valid;
  logic          i_ready = 1'b1;
  logic          o_parity_err, o_frame_err, o_break, o_overrun;
  logic          i_error_rst = 1'b0;
  logic          o_busy;

  uart_rx_core #(.MAX_DATA_WIDTH(MW), .OVERSAMPLE(OS), .SYNC_STAGES(SS)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_tick(i_tick), .i_RX(i_RX),
    .i_cfg_data_bits(i_cfg_data_bits), .i_cfg_parity(i_cfg_parity),
    .i_cfg_stop2(i_cfg_stop2), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_parity_err(o_parity_err), .o_frame_err(o_frame_err),
    .o_break(o_break), .o_overrun(o_overrun), .i_error_rst(i_error_rst),
    .o_busy(o_busy));

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [MW-1:0] data;
    logic          perr;
    logic          ferr;
    logic          brk;
  } frm_t;

  frm_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   tick_per = 1;
  int   ready_mode = 1;   // 0 low, 1 high, 2 random
  int   t_start = 0;
  int   rise_cyc = -1;
  logic prev_valid = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Cycle counter.
  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  // Tick strobe and consumer-ready drivers.
  initial begin
    int tc;
    tc = 0;
    forever begin
      @(posedge i_clk);
      #1;
      tc = (tc >= tick_per - 1) ? 0 : tc + 1;
      i_tick = (tc == 0);
      case (ready_mode)
        0:       i_ready = 1'b0;
        1:       i_ready = 1'b1;
        default: i_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Compare every accepted frame against the model queue.
  initial forever begin
    frm_t e;
    @(negedge i_clk);
    if (i_rstn && o_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = i_rstn && o_valid;
    if (i_rstn && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got data %0h expected no frame", o_data);
      end else begin
        e = exp_q.pop_front();
        chk("frame_data", 32'(o_data), 32'(e.data));
        chk("frame_perr", 32'(o_parity_err), 32'(e.perr));
        chk("frame_ferr", 32'(o_frame_err), 32'(e.ferr));
        chk("frame_brk",  32'(o_break), 32'(e.brk));
      end
    end
  end

  // Drive one frame bit-serially; the expected frame follows from the bits sent.
  task automatic send_frame(input logic [MW-1:0] d, input int cfgb, input int par,
                            input bit s2, input bit bad_par, input bit stop0,
                            input int gbit, input bit push);
    int       eff, per;
    logic [MW-1:0] dm;
    logic [MW:0]   one;
    bit       pen;
    logic     p;
    logic     bits[$];
    frm_t     e;
    eff = (cfgb < 5) ? 5 : ((cfgb > MW) ? MW : cfgb);
    one = 1;
    dm  = d & MW'((one << eff) - 1);
    pen = (par == 1) || (par == 2);
    p   = (^dm) ^ (par == 2);
    if (bad_par) p = !p;
    bits.push_back(1'b0);
    for (int i = 0; i < eff; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(p);
    bits.push_back(!stop0);
    if (s2) bits.push_back(1'b1);
    e.data = dm;
    e.perr = bad_par && pen;
    e.ferr = stop0;
    e.brk  = (dm == 0) && (!pen || !p) && stop0;
    if (push) exp_q.push_back(e);
    i_cfg_data_bits = 4'(cfgb);
    i_cfg_parity    = 2'(par);
    i_cfg_stop2     = s2;
    per     = OS * tick_per;
    t_start = cyc;
    for (int b = 0; b < bits.size(); b++) begin
      if (gbit >= 0 && b == gbit + 1 && tick_per == 1) begin
        // One-cycle inversion near the bit centre corrupts a single sample.
        i_RX = bits[b];  wait_cyc(9);
        i_RX = !bits[b]; wait_cyc(1);
        i_RX = bits[b];  wait_cyc(per - 10);
      end else begin
        i_RX = bits[b];
        wait_cyc(per);
      end
      if (b == 0) begin
        // Config is latched at the start edge; later changes must not matter.
        i_cfg_data_bits = 4'($urandom);
        i_cfg_parity    = 2'($urandom);
        i_cfg_stop2     = 1'($urandom);
      end
    end
    i_RX = 1'b1;
  endtask

  initial begin
    int lat;
    // Reset state
    wait_cyc(4);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_data", 32'(o_data), 0);
    chk("rst_perr", 32'(o_parity_err), 0);
    chk("rst_ferr", 32'(o_frame_err), 0);
    chk("rst_brk", 32'(o_break), 0);
    chk("rst_ovr", 32'(o_overrun), 0);
    chk("rst_busy", 32'(o_busy), 0);
    i_rstn = 1'b1;
    wait_cyc(OS * 2);

    // 8N1 0xA5, held for literal inspection, plus latency
    ready_mode = 0;
    rise_cyc = -1;
    send_frame(9'h0A5, 8, 0, 0, 0, 0, -1, 1);
    wait_cyc(4);
    chk("a5_data", 32'(o_data), 32'h0A5);
    chk("a5_valid", 32'(o_valid), 1);
    chk("a5_flags", 32'({o_parity_err, o_frame_err, o_break}), 0);
    lat = rise_cyc - t_start;
    checks++;
    if (lat < 156 || lat > 158) begin
      errors++;
      $display("FAIL latency: got %0d cycles expected 157 +/-1", lat);
    end
    ready_mode = 1;
    wait_cyc(OS);

    // 7E2 0x3C then 9O1 0x1FF back-to-back
    send_frame(9'h03C, 7, 1, 1, 0, 0, -1, 1);
    send_frame(9'h1FF, 9, 2, 0, 0, 0, -1, 1);
    wait_cyc(OS);

    // 9O1 0x1FF with wrong parity, then a clean one
    ready_mode = 0;
    send_frame(9'h1FF, 9, 2, 0, 1, 0, -1, 1);
    wait_cyc(4);
    chk("badpar_perr", 32'(o_parity_err), 1);
    chk("badpar_data", 32'(o_data), 32'h1FF);
    ready_mode = 1;
    send_frame(9'h1FF, 9, 2, 0, 0, 0, -1, 1);
    wait_cyc(OS);

    // 3-cycle glitch low in IDLE: false start
    i_RX = 1'b0; wait_cyc(3);
    i_RX = 1'b1; wait_cyc(5);
    chk("glitch_busy_hi", 32'(o_busy), 1);
    wait_cyc(OS * 2);
    chk("glitch_busy_lo", 32'(o_busy), 0);
    chk("glitch_novalid", 32'(o_valid), 0);

    // Single-sample flip inside data bit 3
    send_frame(9'h0A5, 8, 0, 0, 0, 0, 3, 1);
    wait_cyc(OS);

    // Break: line low for 20 bit periods, 8N1
    i_cfg_data_bits = 4'd8; i_cfg_parity = 2'b00; i_cfg_stop2 = 1'b0;
    exp_q.push_back('{data: '0, perr: 1'b0, ferr: 1'b1, brk: 1'b1});
    i_RX = 1'b0;
    wait_cyc(OS * 15);
    chk("brk_wait_busy", 32'(o_busy), 1);
    wait_cyc(OS * 5);
    i_RX = 1'b1;
    wait_cyc(OS * 2);
    chk("brk_release_busy", 32'(o_busy), 0);
    send_frame(9'h055, 8, 0, 0, 0, 0, -1, 1);
    wait_cyc(OS);

    // Overrun: consumer stalled, second frame dropped
    ready_mode = 0;
    send_frame(9'h011, 8, 0, 0, 0, 0, -1, 1);
    send_frame(9'h022, 8, 0, 0, 0, 0, -1, 0);
    wait_cyc(4);
    chk("ovr_data", 32'(o_data), 32'h011);
    chk("ovr_set", 32'(o_overrun), 1);
    i_error_rst = 1'b1; wait_cyc(1);
    i_error_rst = 1'b0; wait_cyc(1);
    chk("ovr_clear", 32'(o_overrun), 0);
    ready_mode = 1;
    wait_cyc(3);
    chk("ovr_drained", 32'(o_valid), 0);

    // Reset in the middle of a data field with a frame still presented
    ready_mode = 0;
    send_frame(9'h05A, 8, 0, 0, 0, 0, -1, 0);
    i_cfg_data_bits = 4'd8; i_cfg_parity = 2'b00; i_cfg_stop2 = 1'b0;
    i_RX = 1'b0; wait_cyc(OS);
    i_RX = 1'b1; wait_cyc(OS * 3 + 8);
    #2;
    i_rstn = 1'b0;
    #1;
    chk("arst_valid", 32'(o_valid), 0);
    chk("arst_data", 32'(o_data), 0);
    chk("arst_busy", 32'(o_busy), 0);
    chk("arst_flags", 32'({o_parity_err, o_frame_err, o_break, o_overrun}), 0);
    wait_cyc(3);
    i_rstn = 1'b1;
    ready_mode = 1;
    wait_cyc(OS * 12);
    send_frame(9'h081, 8, 0, 0, 0, 0, -1, 1);
    wait_cyc(OS);

    // Randomized frames, formats and tick rates
    ready_mode = 2;
    for (int n = 0; n < 40; n++) begin
      int cb, pr, gb;
      bit s2, bp, s0;
      tick_per = $urandom_range(1, 3);
      cb = $urandom_range(0, 15);
      pr = $urandom_range(0, 3);
      s2 = 1'($urandom);
      bp = ($urandom_range(0, 5) == 0);
      s0 = ($urandom_range(0, 7) == 0);
      gb = (tick_per == 1 && $urandom_range(0, 1) == 1) ? $urandom_range(0, 4) : -1;
      send_frame(MW'($urandom), cb, pr, s2, bp, s0, gb, 1);
      wait_cyc(OS * tick_per * (s0 ? 1 : 0) + $urandom_range(0, OS * tick_per));
    end
    ready_mode = 1;
    tick_per = 1;
    wait_cyc(OS * 4);
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receiver core, the next-generation successor to the fixed-format receiver inside `uart`. It takes the baud generator's oversample strobe and the raw serial line. It recovers frames whose data width, parity and stop-bit count are set at run time, using a 3-sample majority vote. Each frame is presented on a valid/ready output with per-frame error sideband, and the core sits between the baud generator and the RX FIFO.

## Interface
Parameters:
- MAX_DATA_WIDTH, 9: widest supported data field; `o_data` width.
- OVERSAMPLE, 16: `i_tick` strobes per bit; even, ≥8.
- SYNC_STAGES, 2: `i_RX` synchronizer depth, ≥2.

Ports:
- i_clk  in  1  system clock.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_tick  in  1  oversample strobe, one cycle wide. It may be high every cycle.
- i_RX  in  1  serial line, asynchronous, idle high.
- i_cfg_data_bits  in  4  data bits per frame. Below 5 is treated as 5; above MAX_DATA_WIDTH is treated as MAX_DATA_WIDTH.
- i_cfg_parity  in  2  00 none, 01 even, 10 odd, 11 none.
- i_cfg_stop2  in  1  1 = two stop bits.
- o_data  out  MAX_DATA_WIDTH  received data, LSB-aligned, unused MSBs zero.
- o_valid  out  1  `o_data` and the error flags are valid.
- i_ready  in  1  consumer accepts the frame.
- o_parity_err  out  1  parity mismatch on the presented frame.
- o_frame_err  out  1  a stop bit sampled 0 on the presented frame.
- o_break  out  1  break condition on the presented frame.
- o_overrun  out  1  sticky: a completed frame was dropped.
- i_error_rst  in  1  clears `o_overrun`.
- o_busy  out  1  state is not IDLE.

## Operation
- `i_RX` passes through the SYNC_STAGES flop chain, which resets to 1. All logic uses the synchronized value `rx_s`.
- State machine: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- Tick counter `tcnt` runs 0..OVERSAMPLE-1 and advances only on `i_tick`.
- Majority vote: samples are taken at `tcnt` = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the majority of the three.
- A bit period ends at `tcnt` = OVERSAMPLE-1 with `i_tick`.
- IDLE: on `i_tick` with `rx_s`=0, go to START with `tcnt`=0. At this point latch `cfg_*` into working registers; changes mid-frame are ignored.
- START: if the vote is 1, the start was false; go to IDLE and produce no output. Otherwise go to DATA at the end of the bit.
- DATA: shift the vote in LSB-first and count bits. After the configured count, go to PARITY if parity is enabled, else to STOP.
- PARITY: expected bit = XOR of the data bits (even) or its inverse (odd). A mismatch latches `parity_err`.
- STOP: each stop-bit vote of 0 latches `frame_err`. With two stop bits, both are checked.
- The frame completes at the final vote tick of the last stop bit (OVERSAMPLE/2+1), not at bit end. This gives early resynchronisation.
- On completion, go to IDLE if `rx_s`=1, else go to BRK_WAIT.
- BRK_WAIT: stay until `rx_s`=1, then go to IDLE.
- `o_break` = all data votes 0, the parity vote 0 (when enabled) and the first stop vote 0. `o_frame_err` is then also 1.
- Output holding register, at frame completion:
  - If `o_valid`=1 and `i_ready`=0, the new frame is dropped and `o_overrun` is set.
  - Otherwise `o_data` and the flags load and `o_valid` goes to 1. A handshake in the same cycle accepts the old frame, so no overrun occurs.
- `o_valid` clears on `o_valid && i_ready` when no new frame completes in that cycle.
- `o_overrun` clears on `i_error_rst`. If a set event occurs in the same cycle, set wins.

## Timing
- Reset values: state IDLE, `o_data`=0, `o_valid`=0, `o_parity_err`=0, `o_frame_err`=0, `o_break`=0, `o_overrun`=0, `o_busy`=0. The synchronizer resets to 1.
- Reset mid-frame aborts the frame immediately; nothing is presented afterwards.
- `o_valid` and the sideband rise one clock after the completion cycle.
- Line-to-detection latency is SYNC_STAGES clocks plus up to one tick period.
- With `i_tick` high every cycle, OVERSAMPLE=16, 8N1: `o_valid` rises (1+8)·16 + 10 clocks after the start edge is seen in IDLE, ±1.
- `o_busy` is registered from the state.

## Structure
- Package `uart_pkg`:
  - `parity_t` enum (PAR_NONE, PAR_EVEN, PAR_ODD).
  - `rx_state_t` enum.
  - Constants MIN_DATA_WIDTH=5 and VOTE_OFFSET=1.
- Sub-module `uart_rx_sampler`: synchronizer, `tcnt`, the three-sample vote register, and `vote_valid`/`bit_end` strobes.
- The core holds the FSM, shift register, parity and output register.

## Test plan
- Send 8N1 0xA5, tick every cycle, `i_ready`=1 → one `o_valid` pulse, `o_data`=0x0A5, all error flags 0.
- Send 7E2 0x3C, then 9O1 0x1FF, back-to-back → 0x03C and 0x1FF in order, no errors. For 0x1FF, force a wrong parity bit → `o_parity_err`=1 on that frame only.
- Send a 3-cycle-wide glitch low in IDLE → START aborts, no `o_valid`, `o_busy` returns to 0. Separately, flip one of the three samples in a data bit → the byte is still correct.
- Hold `i_RX` low for 20 bit periods, 8N1 → one frame with `o_data`=0, `o_break`=1, `o_frame_err`=1. BRK_WAIT holds until the line rises, and the next frame, 0x55, is received cleanly.
- Hold `i_ready`=0 and send 0x11 then 0x22 → `o_data` stays 0x011 and `o_overrun`=1. Pulsing `i_error_rst` clears `o_overrun`, and `i_ready`=1 then drains 0x011.
- Deassert `i_rstn` mid-DATA → all outputs return to their reset values asynchronously. After release, a new 0x81 frame is received correctly.
